// File: rtl/zorro_int_ctrl_pkg.sv
// Shared constants and types for the Zorro III interrupt controller.
package zorro_int_pkg;

  // Register index, taken from ADDR[3:2]
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_MASK   = 2'd1;
  localparam logic [1:0] REG_VECTOR = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // Global enable position in the MASK register
  localparam int MASK_GLOBAL_BIT = 31;

  // Bus handshake states
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

endpackage

// File: rtl/zorro_int_ctrl_if.sv
// Zorro III slave-cycle bus bundle seen by the interrupt controller.
interface zorro_int_ctrl_if;
  logic [27:0] ADDR;
  logic        READ;
  logic        FCS_n;
  logic        slave_cycle;
  logic        configured;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        rdata_oe;
  logic        int_dtack;

  // Host / bus side
  modport master (
    output ADDR, READ, FCS_n, slave_cycle, configured, WDATA,
    input  RDATA, rdata_oe, int_dtack
  );

  // Controller side
  modport slave (
    input  ADDR, READ, FCS_n, slave_cycle, configured, WDATA,
    output RDATA, rdata_oe, int_dtack
  );
endinterface

// File: rtl/zorro_int_ctrl_src_sync.sv
// One interrupt source: 2-flop synchronizer, rising-edge detect and a
// pending latch where a new edge beats a simultaneous clear.
module int_src_sync #(
  parameter bit EDGE = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic src_in,
  input  logic clr,
  output logic pending
);
  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;
  logic latch_reg;
  logic rise;

  // Bring the asynchronous request into CLK and keep a delayed copy
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= src_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~prev_reg;

  // Edge latch: the set term is ORed in after the clear so it wins
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) latch_reg <= 1'b0;
    else       latch_reg <= (latch_reg & ~clr) | rise;
  end

  // Level sources follow the synchronized input and ignore clears
  assign pending = EDGE ? latch_reg : sync2_reg;

endmodule

// File: rtl/zorro_int_ctrl.sv
// Zorro III interrupt controller: NUM_SRC maskable sources, four longword
// registers behind BASE_ADDR, active-low INT_n and a delayed DTACK.
module zorro_int_ctrl
  import zorro_int_pkg::*;
#(
  parameter int                 NUM_SRC     = 4,
  parameter logic [27:0]        BASE_ADDR   = 28'h900000,
  parameter logic [NUM_SRC-1:0] EDGE_MODE   = {NUM_SRC{1'b1}},
  parameter int                 DTACK_DELAY = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  zorro_int_ctrl_if.slave    bus,
  input  logic [NUM_SRC-1:0] SRC_INT,
  output logic               INT_n
);
  state_t           state_reg;
  logic [2:0]       cnt_reg;
  logic [1:0]       reg_idx_reg;
  logic             read_reg;
  logic [NUM_SRC:0] wdata_reg;
  logic             dtack_reg;
  logic             oe_reg;
  logic [31:0]      rdata_reg;
  logic             int_n_reg;
  logic [NUM_SRC-1:0] mask_reg;
  logic             gen_en_reg;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] clr_next;
  logic [4:0]       vec_idx;
  logic             vec_valid;
  logic             hit;
  logic             commit;
  logic [31:0]      rd_next;
  logic             unused_bus;

  // Address bits [1:0] and WDATA bits outside the register fields carry no meaning here
  assign unused_bus = ^{bus.ADDR[1:0], bus.WDATA};

  assign hit = bus.slave_cycle && bus.configured &&
               (bus.ADDR[27:4] == BASE_ADDR[27:4]);

  // The single edge where a cycle's side effects and read data take effect
  assign commit = (state_reg == WAIT) && !bus.FCS_n &&
                  (cnt_reg == 3'(DTACK_DELAY));

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : gen_src
      int_src_sync #(.EDGE(EDGE_MODE[gi])) u_src (
        .CLK     (CLK),
        .RESET   (RESET),
        .src_in  (SRC_INT[gi]),
        .clr     (clr_next[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

  assign active    = pending & mask_reg & {NUM_SRC{gen_en_reg}};
  assign vec_valid = |active;

  // Lowest-numbered active source wins
  always_comb begin
    vec_idx = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 5'(i);
    end
  end

  // Read mux, sampled on the commit edge
  always_comb begin
    rd_next = 32'd0;
    case (reg_idx_reg)
      REG_STATUS: rd_next = 32'(pending);
      REG_MASK: begin
        rd_next = 32'(mask_reg);
        rd_next[MASK_GLOBAL_BIT] = gen_en_reg;
      end
      REG_VECTOR: rd_next = {vec_valid, 26'd0, vec_idx};
      default:    rd_next = 32'd0;
    endcase
  end

  // Pending clears: W1C on STATUS writes, acknowledged source on VECTOR reads
  always_comb begin
    clr_next = '0;
    if (commit) begin
      if (read_reg && (reg_idx_reg == REG_VECTOR)) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          clr_next[i] = vec_valid && (vec_idx == 5'(i));
        end
      end else if (!read_reg && (reg_idx_reg == REG_STATUS)) begin
        clr_next = wdata_reg[NUM_SRC-1:0];
      end
    end
  end

  // Handshake FSM with registered DTACK, drive enable and read data
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= IDLE;
      cnt_reg     <= 3'd0;
      reg_idx_reg <= 2'd0;
      read_reg    <= 1'b0;
      wdata_reg   <= '0;
      dtack_reg   <= 1'b0;
      oe_reg      <= 1'b0;
      rdata_reg   <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hit && !bus.FCS_n) begin
            state_reg   <= WAIT;
            cnt_reg     <= 3'd0;
            reg_idx_reg <= bus.ADDR[3:2];
            read_reg    <= bus.READ;
            wdata_reg   <= {bus.WDATA[MASK_GLOBAL_BIT], bus.WDATA[NUM_SRC-1:0]};
          end
        end
        WAIT: begin
          if (bus.FCS_n) begin
            state_reg <= IDLE;
          end else if (commit) begin
            state_reg <= ACK;
            dtack_reg <= 1'b1;
            oe_reg    <= read_reg;
            rdata_reg <= rd_next;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        ACK: begin
          if (bus.FCS_n) begin
            state_reg <= IDLE;
            dtack_reg <= 1'b0;
            oe_reg    <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // MASK register, written only on a committed write cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask_reg   <= '0;
      gen_en_reg <= 1'b0;
    end else if (commit && !read_reg && (reg_idx_reg == REG_MASK)) begin
      mask_reg   <= wdata_reg[NUM_SRC-1:0];
      gen_en_reg <= wdata_reg[NUM_SRC];
    end
  end

  // Registered interrupt request
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) int_n_reg <= 1'b1;
    else       int_n_reg <= ~|active;
  end

  assign INT_n         = int_n_reg;
  assign bus.int_dtack = dtack_reg;
  assign bus.rdata_oe  = oe_reg;
  assign bus.RDATA     = rdata_reg;

endmodule

// File: tb/tb_zorro_int_ctrl.sv
// Directed bench: instance A uses defaults, instance B has a level source
// on bit 0 and three DTACK wait states.
module tb_zorro_int_ctrl;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] src_a = 4'd0;
  logic [3:0] src_b = 4'd0;
  logic       int_n_a;
  logic       int_n_b;
  int         n_assert = 0;
  int         n_fail = 0;
  logic [31:0] q;

  localparam logic [27:0] A_STATUS = 28'h900000;
  localparam logic [27:0] A_MASK   = 28'h900004;
  localparam logic [27:0] A_VECTOR = 28'h900008;
  localparam logic [27:0] A_RSVD   = 28'h90000C;

  zorro_int_ctrl_if ifa();
  zorro_int_ctrl_if ifb();

  zorro_int_ctrl u_a (
    .CLK(CLK), .RESET(RESET), .bus(ifa.slave), .SRC_INT(src_a), .INT_n(int_n_a)
  );

  zorro_int_ctrl #(.EDGE_MODE(4'b1110), .DTACK_DELAY(3)) u_b (
    .CLK(CLK), .RESET(RESET), .bus(ifb.slave), .SRC_INT(src_b), .INT_n(int_n_b)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic [27:0] a, input logic rd,
                       input logic [31:0] wd, input logic fcs);
    if (d == 0) begin
      ifa.ADDR = a; ifa.READ = rd; ifa.WDATA = wd; ifa.FCS_n = fcs;
      ifa.slave_cycle = 1'b1; ifa.configured = 1'b1;
    end else begin
      ifb.ADDR = a; ifb.READ = rd; ifb.WDATA = wd; ifb.FCS_n = fcs;
      ifb.slave_cycle = 1'b1; ifb.configured = 1'b1;
    end
  endtask

  task automatic release_bus(input int d);
    if (d == 0) ifa.FCS_n = 1'b1;
    else        ifb.FCS_n = 1'b1;
  endtask

  function automatic logic get_dtack(input int d);
    return (d == 0) ? ifa.int_dtack : ifb.int_dtack;
  endfunction

  function automatic logic get_oe(input int d);
    return (d == 0) ? ifa.rdata_oe : ifb.rdata_oe;
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? ifa.RDATA : ifb.RDATA;
  endfunction

  // Complete bus cycle; returns one negedge after the edge that drops DTACK
  task automatic bus(input int d, input logic [27:0] a, input logic rd,
                     input logic [31:0] wd, output logic [31:0] rq);
    int k;
    drive(d, a, rd, wd, 1'b0);
    k = 0;
    tick(1);
    while (!get_dtack(d) && k < 20) begin
      tick(1);
      k++;
    end
    chk("dtack_wait", 32'(get_dtack(d)), 32'd1);
    rq = get_rdata(d);
    release_bus(d);
    tick(1);
    $display("bus dut=%0d %s addr=%07h wdata=%08h rdata=%08h", d, rd ? "RD" : "WR", a, wd, rq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.ADDR = '0; ifa.READ = 1'b0; ifa.WDATA = '0; ifa.FCS_n = 1'b1;
    ifa.slave_cycle = 1'b0; ifa.configured = 1'b0;
    ifb.ADDR = '0; ifb.READ = 1'b0; ifb.WDATA = '0; ifb.FCS_n = 1'b1;
    ifb.slave_cycle = 1'b0; ifb.configured = 1'b0;
    tick(2);
    RESET = 1'b0;
    tick(1);

    // Reset values
    chk("rst_dtack", 32'(ifa.int_dtack), 32'd0);
    chk("rst_oe", 32'(ifa.rdata_oe), 32'd0);
    chk("rst_rdata", ifa.RDATA, 32'd0);
    chk("rst_int_n_a", 32'(int_n_a), 32'd1);
    chk("rst_int_n_b", 32'(int_n_b), 32'd1);

    // Masked edge on source 0 latches but does not interrupt
    src_a[0] = 1'b1;
    tick(4);
    chk("masked_int_n", 32'(int_n_a), 32'd1);

    // STATUS read with DTACK timing: strobe sampled, then high two edges later
    drive(0, A_STATUS, 1'b1, 32'd0, 1'b0);
    tick(1);
    chk("dtack_e1", 32'(ifa.int_dtack), 32'd0);
    tick(1);
    chk("dtack_e2", 32'(ifa.int_dtack), 32'd0);
    tick(1);
    chk("dtack_e3", 32'(ifa.int_dtack), 32'd1);
    chk("oe_read", 32'(ifa.rdata_oe), 32'd1);
    chk("status_p0", ifa.RDATA, 32'h1);
    release_bus(0);
    tick(1);
    chk("dtack_fall", 32'(ifa.int_dtack), 32'd0);
    chk("oe_fall", 32'(ifa.rdata_oe), 32'd0);
    $display("bus dut=0 RD addr=%07h status timing", A_STATUS);

    // MASK write: INT_n falls one edge after the commit
    drive(0, A_MASK, 1'b0, 32'h80000001, 1'b0);
    tick(3);
    chk("mask_commit_dtack", 32'(ifa.int_dtack), 32'd1);
    chk("oe_write", 32'(ifa.rdata_oe), 32'd0);
    chk("int_n_at_commit", 32'(int_n_a), 32'd1);
    release_bus(0);
    tick(1);
    chk("int_n_after_commit", 32'(int_n_a), 32'd0);
    $display("bus dut=0 WR addr=%07h mask timing", A_MASK);

    bus(0, A_MASK, 1'b1, 32'd0, q);
    chk("mask_readback", q, 32'h80000001);

    // W1C on source 0 releases INT_n one edge after the commit
    bus(0, A_STATUS, 1'b0, 32'h1, q);
    chk("w1c_int_n", 32'(int_n_a), 32'd1);

    bus(0, A_RSVD, 1'b1, 32'd0, q);
    chk("rsvd_read", q, 32'd0);

    // Vector priority across sources 1 and 3
    src_a[1] = 1'b1;
    src_a[3] = 1'b1;
    tick(4);
    bus(0, A_MASK, 1'b0, 32'h8000000A, q);
    chk("vec_int_n_low", 32'(int_n_a), 32'd0);
    bus(0, A_VECTOR, 1'b1, 32'd0, q);
    chk("vector_1", q, 32'h80000001);
    chk("vec_int_n_still", 32'(int_n_a), 32'd0);
    bus(0, A_VECTOR, 1'b1, 32'd0, q);
    chk("vector_3", q, 32'h80000003);
    chk("vec_int_n_high", 32'(int_n_a), 32'd1);
    bus(0, A_VECTOR, 1'b1, 32'd0, q);
    chk("vector_none", q, 32'h0);
    bus(0, A_STATUS, 1'b1, 32'd0, q);
    chk("status_after_vec", q, 32'h0);

    // W1C on bit 2 at the same edge a new source 2 edge latches: set wins
    src_a[2] = 1'b1;
    drive(0, A_STATUS, 1'b0, 32'h4, 1'b0);
    tick(3);
    chk("setwin_dtack", 32'(ifa.int_dtack), 32'd1);
    release_bus(0);
    tick(1);
    $display("bus dut=0 WR addr=%07h wdata=00000004 set-wins", A_STATUS);
    bus(0, A_STATUS, 1'b1, 32'd0, q);
    chk("set_wins", q, 32'h4);

    // Level source 0 on B
    bus(1, A_MASK, 1'b0, 32'h80000001, q);
    src_b[0] = 1'b1;
    tick(2);
    chk("lvl_int_n_e2", 32'(int_n_b), 32'd1);
    tick(1);
    chk("lvl_int_n_e3", 32'(int_n_b), 32'd0);
    bus(1, A_STATUS, 1'b0, 32'h1, q);
    bus(1, A_STATUS, 1'b1, 32'd0, q);
    chk("lvl_w1c_ignored", q, 32'h1);
    src_b[0] = 1'b0;
    tick(2);
    chk("lvl_drop_e2", 32'(int_n_b), 32'd0);
    tick(1);
    chk("lvl_drop_e3", 32'(int_n_b), 32'd1);
    bus(1, A_STATUS, 1'b1, 32'd0, q);
    chk("lvl_status_zero", q, 32'h0);

    // Strobe withdrawn during WAIT: no ack, no MASK change
    drive(1, A_MASK, 1'b0, 32'h8000000F, 1'b0);
    tick(2);
    chk("abort_wait_dtack", 32'(ifb.int_dtack), 32'd0);
    release_bus(1);
    tick(1);
    chk("abort_dtack_e1", 32'(ifb.int_dtack), 32'd0);
    tick(4);
    chk("abort_dtack_late", 32'(ifb.int_dtack), 32'd0);
    $display("bus dut=1 WR addr=%07h wdata=8000000F aborted", A_MASK);
    bus(1, A_MASK, 1'b1, 32'd0, q);
    chk("abort_mask", q, 32'h80000001);

    // Reset pulse while in ACK
    src_b[1] = 1'b1;
    tick(4);
    chk("b_src1_masked", 32'(int_n_b), 32'd1);
    drive(1, A_MASK, 1'b0, 32'h80000002, 1'b0);
    tick(5);
    chk("b_ack_dtack", 32'(ifb.int_dtack), 32'd1);
    chk("b_ack_rdata", ifb.RDATA, 32'h80000001);
    tick(1);
    chk("b_ack_int_n", 32'(int_n_b), 32'd0);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid_dtack", 32'(ifb.int_dtack), 32'd0);
    chk("rst_mid_oe", 32'(get_oe(1)), 32'd0);
    chk("rst_mid_rdata", ifb.RDATA, 32'd0);
    chk("rst_mid_int_n", 32'(int_n_b), 32'd1);
    $display("bus dut=1 WR addr=%07h wdata=80000002 reset in ACK", A_MASK);
    @(negedge CLK);
    RESET = 1'b0;
    release_bus(1);
    tick(1);
    bus(1, A_MASK, 1'b1, 32'd0, q);
    chk("rst_mask_zero", q, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/zorro_int_ctrl.md
# zorro_int_ctrl

Parametrised Zorro III interrupt controller that replaces the single-source INTREG latch with NUM_SRC independently maskable sources (NCR SCSI core plus future on-card sources). It sits behind the board's Z3 BAR at BASE_ADDR and exposes four longword registers: status, mask, vector-acknowledge and reserved. It drives the shared active-low INT_n line and a registered DTACK handshake with programmable wait states.

## Interface
- NUM_SRC, default 4: number of interrupt sources, 1..16.
- BASE_ADDR, default 28'h900000: register block offset within the BAR; bits [3:0] must be zero.
- EDGE_MODE, default all ones: per-source mode. 1 = rising-edge latched; 0 = level, not latched.
- DTACK_DELAY, default 1: wait cycles from decode to int_dtack assertion, 0..7.
- CLK  in  1  board clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ADDR  in  28  Z3 address within BAR.
- READ  in  1  1 = read cycle, 0 = write.
- FCS_n  in  1  Z3 full cycle strobe, active low.
- slave_cycle  in  1  board is addressed slave.
- configured  in  1  autoconfig complete.
- WDATA  in  32  write data, valid while FCS_n is low.
- SRC_INT  in  NUM_SRC  asynchronous interrupt requests, active high.
- RDATA  out  32  registered read data, valid while int_dtack is high.
- rdata_oe  out  1  data-bus drive enable, equal to int_dtack && READ.
- int_dtack  out  1  cycle acknowledge.
- INT_n  out  1  interrupt request, active low.

## Operation
- Sources pass through a 2-flop synchronizer.
  - Edge sources set pending[i] on the synchronized 0→1 transition.
  - Level sources: pending[i] = synchronized level.
- Register select:
  - hit = slave_cycle && configured && ADDR[27:4] == BASE_ADDR[27:4].
  - Register index = ADDR[3:2].
- Register 0x0, STATUS:
  - Read returns pending, zero-extended to 32 bits.
  - Write-1-to-clear on edge bits; level bits and writes of 0 are ignored.
- Register 0x4, MASK:
  - Read/write. Bits [NUM_SRC-1:0] are per-source enables; bit 31 is the global enable.
  - Other bits read 0.
  - Reset value is 0 (all disabled).
- Register 0x8, VECTOR:
  - Read returns {valid, 26'b0, idx[4:0]}, where idx is the lowest-numbered active source.
  - active = pending & mask & {NUM_SRC{mask[31]}}.
  - The read clears pending[idx] if that source is edge-mode.
  - With no active source it returns 0 and clears nothing.
  - Writes are ignored.
- Register 0xC: reserved. Reads return 0, writes are ignored, and the cycle is still acknowledged.
- INT_n is registered: INT_n <= ~|active.
- Handshake FSM:
  - IDLE → WAIT when hit && !FCS_n. ADDR, READ and WDATA are latched on this transition.
  - WAIT counts DTACK_DELAY cycles, then goes to ACK. With DTACK_DELAY = 0 it goes to ACK on the next edge.
  - All register side effects commit exactly once, on the WAIT→ACK edge. RDATA is loaded on the same edge.
  - In ACK, int_dtack = 1. Return to IDLE when FCS_n = 1.
  - FCS_n rising during WAIT aborts to IDLE with no side effect.
- Simultaneous events on the same edge bit:
  - A new edge in the same cycle as a W1C or VECTOR clear leaves the bit set (set wins).
  - A MASK write and an edge in the same cycle both take effect.
- A VECTOR read samples `active` at the commit edge, not at decode.

## Timing
- All outputs are reset to: int_dtack 0, rdata_oe 0, RDATA 0, INT_n 1. Internally, pending = 0, mask = 0 and the FSM is in IDLE.
- Source to pending: 3 CLK edges (2 synchronizer + 1 edge detect/latch).
- Pending to INT_n low: 1 further edge, provided the source is unmasked.
- Strobe (FCS_n low sampled) to int_dtack high: DTACK_DELAY + 1 edges.
- int_dtack falls on the first edge that samples FCS_n high.
- Clear commit to INT_n high: 1 edge, if no other source is active.
- RESET asserted mid-cycle forces IDLE and all reset values immediately. No partial commit survives.

## Structure
- Package zorro_int_pkg holds:
  - register offset constants REG_STATUS, REG_MASK, REG_VECTOR, REG_RSVD;
  - the FSM state enum {IDLE, WAIT, ACK};
  - the MASK_GLOBAL_BIT = 31 constant.
- Sub-module int_src_sync, instantiated NUM_SRC times, contains:
  - the 2-flop synchronizer;
  - the edge detector;
  - the per-source pending flop with set-wins clear.
- Top level contains the decode, handshake FSM, priority encoder and register file.

## Test plan
- Reset, then NCR edge on SRC_INT[0] with MASK = 0 → pending 0x1, INT_n stays 1. Write MASK 0x80000001 → INT_n 0 one edge after the commit.
- Default DTACK_DELAY = 1: FCS_n low with ADDR = 0x900000 read → int_dtack high exactly 2 edges later. FCS_n high → int_dtack 0 on the next edge.
- Sources 1 and 3 are edge-mode and pending, MASK = 0x8000000A. VECTOR read → 0x80000001; second read → 0x80000003; third → 0x0, and INT_n returns to 1.
- STATUS write 0x4 on the same cycle as a fresh edge on source 2 → pending[2] remains 1.
- Level source (EDGE_MODE bit 0 = 0) held high: W1C to STATUS bit 0 has no effect. Deasserting SRC_INT[0] → pending[0] = 0 after 2 edges.
- Edge case: FCS_n rises during WAIT (DTACK_DELAY = 3) → no int_dtack and no MASK change. RESET pulse in ACK → int_dtack 0, MASK 0 immediately.
